alu_result_fifo: RTL and testbench

Downstream capture stage for the Lab 4 ALU. It stores successive 8-bit ALU results in a small FIFO when the user presses a push key, and releases them in arrival order on a pop key. The oldest stored result drives two HEX displays, and occupancy drives LEDs. It sits between the ALU's `ALUout` and the board's HEX/LEDR outputs, replacing the single 8-bit result register with a history buffer.

---
 rtl/alu_result_fifo.sv | 210 +++++++++++++++++++++
 tb/tb_alu_result_fifo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_fifo (with helper: decoder)
// Brief    : History FIFO for ALU results. Key-driven push/pop through edge
//            detected synchronizers. Oldest entry is shown on two HEX digits.
//            Optional macro ALU_FIFO_OVERWRITE_OLDEST_EN: a push into a full
//            FIFO replaces the oldest entry instead of being dropped.
// Revision : 1.0 - initial release
// ============================================================================

module decoder (
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  always_comb begin
    segments = 7'b1111111;
    case (nibble)
      4'h0: segments = 7'b1000000;
      4'h1: segments = 7'b1111001;
      4'h2: segments = 7'b0100100;
      4'h3: segments = 7'b0110000;
      4'h4: segments = 7'b0011001;
      4'h5: segments = 7'b0010010;
      4'h6: segments = 7'b0000010;
      4'h7: segments = 7'b1111000;
      4'h8: segments = 7'b0000000;
      4'h9: segments = 7'b0010000;
      4'hA: segments = 7'b0001000;
      4'hB: segments = 7'b0000011;
      4'hC: segments = 7'b1000110;
      4'hD: segments = 7'b0100001;
      4'hE: segments = 7'b0000110;
      4'hF: segments = 7'b0001110;
      default: segments = 7'b1111111;
    endcase
  end

endmodule

module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     push_req,
  input  logic                     pop_req,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic [6:0]               hex_head_30,
  output logic [6:0]               hex_head_74
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_t;

  // Request synchronizers: bit 0 = push, bit 1 = pop
  logic [1:0] w_req;
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_prev;
  logic [1:0] w_pulse;

  assign w_req   = {pop_req, push_req};
  assign w_pulse = r_sync2 & ~r_prev;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
      r_prev  <= 2'b00;
    end else begin
      r_sync1 <= w_req;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  occ_t             w_occ;
  logic             w_push;
  logic             w_pop;
  logic             w_write;
  logic             w_adv_wr;
  logic             w_adv_rd;
  logic             w_set_ovf;
  logic [CW-1:0]    w_cnt_next;

  assign w_push = w_pulse[0];
  assign w_pop  = w_pulse[1];

  always_comb begin
    w_occ = OCC_PARTIAL;
    if (r_count == '0)
      w_occ = OCC_EMPTY;
    else if (r_count == C_DEPTH)
      w_occ = OCC_FULL;
  end

  always_comb begin
    w_write    = 1'b0;
    w_adv_wr   = 1'b0;
    w_adv_rd   = 1'b0;
    w_set_ovf  = 1'b0;
    w_cnt_next = r_count;
    case (w_occ)
      OCC_EMPTY: begin
        // A pop with nothing stored is meaningless, so only the push counts
        if (w_push) begin
          w_write    = 1'b1;
          w_adv_wr   = 1'b1;
          w_cnt_next = r_count + CW'(1);
        end
      end
      default: begin
        if (w_push && w_pop) begin
          w_write  = 1'b1;
          w_adv_wr = 1'b1;
          w_adv_rd = 1'b1;
        end else if (w_push) begin
          if (w_occ == OCC_FULL) begin
            w_set_ovf = 1'b1;
`ifdef ALU_FIFO_OVERWRITE_OLDEST_EN
            w_write  = 1'b1;
            w_adv_wr = 1'b1;
            w_adv_rd = 1'b1;
`endif
          end else begin
            w_write    = 1'b1;
            w_adv_wr   = 1'b1;
            w_cnt_next = r_count + CW'(1);
          end
        end else if (w_pop) begin
          w_adv_rd   = 1'b1;
          w_cnt_next = r_count - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_adv_wr)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_adv_rd)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_cnt_next;
      if (w_set_ovf)
        r_overflow <= 1'b1;
    end
  end

  // Storage is left unreset; it is masked from head while empty
  always_ff @(posedge clock) begin
    if (w_write)
      r_mem[r_wr_ptr] <= alu_result;
  end

  assign count    = r_count;
  assign empty    = (w_occ == OCC_EMPTY);
  assign full     = (w_occ == OCC_FULL);
  assign overflow = r_overflow;
  assign head     = empty ? '0 : r_mem[r_rd_ptr];

  logic [7:0] w_hex_src;

  generate
    if (WIDTH >= 8) begin : g_hex_wide
      assign w_hex_src = head[7:0];
    end else begin : g_hex_narrow
      assign w_hex_src = {{(8-WIDTH){1'b0}}, head};
    end
  endgenerate

  decoder u_dec_30 (
    .nibble   (w_hex_src[3:0]),
    .segments (hex_head_30)
  );

  decoder u_dec_74 (
    .nibble   (w_hex_src[7:4]),
    .segments (hex_head_74)
  );

endmodule

`default_nettype wire

// File: tb/tb_alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_fifo
// Brief    : Directed, table-driven bench for alu_result_fifo.
// Revision : 1.0 - initial release
// ============================================================================

module tb_alu_result_fifo;

`ifdef ALU_FIFO_OVERWRITE_OLDEST_EN
  localparam bit C_OW = 1'b1;
`else
  localparam bit C_OW = 1'b0;
`endif

  logic       clock;
  logic       reset_n;
  logic [7:0] alu_result;
  logic       push_req;
  logic       pop_req;
  logic [7:0] head;
  logic [2:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic [6:0] hex_head_30;
  logic [6:0] hex_head_74;

  int checks = 0;
  int errors = 0;

  alu_result_fifo #(.DEPTH(4), .WIDTH(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .alu_result  (alu_result),
    .push_req    (push_req),
    .pop_req     (pop_req),
    .head        (head),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow),
    .hex_head_30 (hex_head_30),
    .hex_head_74 (hex_head_74)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       push;
    logic       pop;
    logic [7:0] data;
    logic [2:0] cnt;
    logic [7:0] hd;
    logic       emp;
    logic       ful;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] c, input logic [7:0] h,
                           input logic e, input logic f, input logic o);
    check({tag, " count"}, 32'(count), 32'(c));
    check({tag, " head"}, 32'(head), 32'(h));
    check({tag, " empty"}, 32'(empty), 32'(e));
    check({tag, " full"}, 32'(full), 32'(f));
    check({tag, " overflow"}, 32'(overflow), 32'(o));
    check({tag, " hex30"}, 32'(hex_head_30), 32'(seg(h[3:0])));
    check({tag, " hex74"}, 32'(hex_head_74), 32'(seg(h[7:4])));
  endtask

  task automatic add(input logic pu, input logic po, input logic [7:0] d, input logic [2:0] c,
                     input logic [7:0] h, input logic e, input logic f, input logic o);
    vec_t v;
    v.push = pu; v.pop = po; v.data = d; v.cnt = c;
    v.hd = h; v.emp = e; v.ful = f; v.ovf = o;
    vecs.push_back(v);
  endtask

  // Press keys, check right after the third edge, then release and let the
  // synchronizers settle before the next press.
  task automatic press(input logic pu, input logic po, input logic [7:0] d);
    @(negedge clock);
    push_req   = pu;
    pop_req    = po;
    alu_result = d;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic release_keys();
    @(negedge clock);
    push_req = 1'b0;
    pop_req  = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  initial begin
    reset_n    = 1'b0;
    push_req   = 1'b0;
    pop_req    = 1'b0;
    alu_result = 8'h00;

    #3;
    check_all("reset", 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // First push: exact latency, data sampled at the write edge, held key
    @(negedge clock);
    push_req   = 1'b1;
    alu_result = 8'h2A;
    repeat (2) @(posedge clock);
    #1;
    check("latency edge2 count", 32'(count), 32'd0);
    @(posedge clock);
    #1;
    check_all("first push", 3'd1, 8'h2A, 1'b0, 1'b0, 1'b0);
    alu_result = 8'hFF;
    repeat (17) @(posedge clock);
    #1;
    check_all("held key", 3'd1, 8'h2A, 1'b0, 1'b0, 1'b0);
    release_keys();
    press(1'b0, 1'b1, 8'h00);
    check_all("pop first", 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    release_keys();

    //  push pop data  cnt  head   emp  ful  ovf
    add(1, 0, 8'h01, 3'd1, 8'h01, 0, 0, 0);
    add(1, 0, 8'h02, 3'd2, 8'h01, 0, 0, 0);
    add(1, 0, 8'h03, 3'd3, 8'h01, 0, 0, 0);
    add(1, 0, 8'h04, 3'd4, 8'h01, 0, 1, 0);
    add(1, 1, 8'h77, 3'd4, 8'h02, 0, 1, 0);
    add(0, 1, 8'h00, 3'd3, 8'h03, 0, 0, 0);
    add(0, 1, 8'h00, 3'd2, 8'h04, 0, 0, 0);
    add(0, 1, 8'h00, 3'd1, 8'h77, 0, 0, 0);
    add(0, 1, 8'h00, 3'd0, 8'h00, 1, 0, 0);
    add(0, 1, 8'h00, 3'd0, 8'h00, 1, 0, 0);
    add(1, 1, 8'h10, 3'd1, 8'h10, 0, 0, 0);
    add(0, 1, 8'h00, 3'd0, 8'h00, 1, 0, 0);
    add(1, 0, 8'h01, 3'd1, 8'h01, 0, 0, 0);
    add(1, 0, 8'h02, 3'd2, 8'h01, 0, 0, 0);
    add(1, 0, 8'h03, 3'd3, 8'h01, 0, 0, 0);
    add(1, 0, 8'h04, 3'd4, 8'h01, 0, 1, 0);
    add(1, 0, 8'h55, 3'd4, C_OW ? 8'h02 : 8'h01, 0, 1, 1);
    add(0, 1, 8'h00, 3'd3, C_OW ? 8'h03 : 8'h02, 0, 0, 1);
    add(0, 1, 8'h00, 3'd2, C_OW ? 8'h04 : 8'h03, 0, 0, 1);
    add(0, 1, 8'h00, 3'd1, C_OW ? 8'h55 : 8'h04, 0, 0, 1);
    add(0, 1, 8'h00, 3'd0, 8'h00, 1, 0, 1);
    add(1, 0, 8'h11, 3'd1, 8'h11, 0, 0, 1);
    add(1, 0, 8'h22, 3'd2, 8'h11, 0, 0, 1);
    add(1, 0, 8'h33, 3'd3, 8'h11, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      press(vecs[i].push, vecs[i].pop, vecs[i].data);
      check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].hd,
                vecs[i].emp, vecs[i].ful, vecs[i].ovf);
      release_keys();
    end

    // Asynchronous reset in the middle of a cycle with 3 entries and overflow
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_all("async reset", 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    press(1'b1, 1'b0, 8'hC3);
    check_all("after reset", 3'd1, 8'hC3, 1'b0, 1'b0, 1'b0);
    release_keys();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
